controle_sirene_alarme: RTL and testbench
=========================================

# controle_sirene_alarme

Sequential alarm-handling stage directly downstream of the residential alarm combinational logic. It consumes the alarm request `A` and adds arming/disarming, an entry delay, a time-limited siren and alarm memory. It also keeps a saturating event counter. All outputs are registered and drive the siren driver and the panel indicators.

## Interface
- `ENTRY_DELAY`, default 10: clock cycles spent in the entry-delay state before the siren sounds; legal range 1..255.
- `SIREN_TIME`, default 20: clock cycles the siren stays on per trigger; legal range 1..255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `A`  in  1  alarm request from the combinational alarm logic; level, sampled on `clk`.
- `ARM`  in  1  arm request; single-cycle pulse or level.
- `DISARM`  in  1  disarm request; single-cycle pulse or level.
- `ARMED`  out  1  high in every state except DISARMED.
- `PENDING`  out  1  high only in ENTRY.
- `SIREN`  out  1  high only in SIREN.
- `MEMO`  out  1  high only in MEMORY.
- `EVENTS`  out  4  count of triggers since the last accepted arm; saturates at 15.

## Operation
- States: DISARMED, ARMED_IDLE, ENTRY, SIREN, MEMORY. One 8-bit down-counter is shared by ENTRY and SIREN.
- DISARMED:
  - `ARM`=1 goes to ARMED_IDLE and clears `EVENTS` to 0 on the same edge.
  - `A` is ignored.
- ARMED_IDLE:
  - `A`=1 goes to ENTRY.
  - Counter loads `ENTRY_DELAY`-1 and `EVENTS` increments (saturating) on the same edge.
- ENTRY:
  - Counter decrements each cycle.
  - At counter=0, the next edge goes to SIREN and the counter loads `SIREN_TIME`-1.
  - `A` is ignored while in ENTRY.
- SIREN:
  - Counter decrements each cycle.
  - At counter=0, the next edge goes to MEMORY.
- MEMORY:
  - Silent; still armed.
  - `A`=1 re-triggers: goes to ENTRY exactly as from ARMED_IDLE, including the `EVENTS` increment.
- DISARM:
  - `DISARM`=1 in any state other than DISARMED goes to DISARMED on the next edge and aborts any countdown.
  - `EVENTS` is not cleared by disarm; it is held for inspection.
- Priority when inputs coincide: `DISARM` > `ARM` > `A`.
  - `ARM` and `DISARM` together in DISARMED: stay DISARMED, `EVENTS` unchanged.
  - `ARM` in any armed state: ignored.
- Saturation: `EVENTS`=15 plus a new trigger stays 15; no wrap-around.
- Outputs are decoded from the state register only; no combinational path from any input to any output.

## Timing
- Reset (`rst_n`=0, asynchronous): state DISARMED, counter 0, `ARMED`=`PENDING`=`SIREN`=`MEMO`=0, `EVENTS`=0.
- Reset mid-countdown takes effect immediately, without waiting for `clk`. After `rst_n` deasserts, the block stays DISARMED until `ARM` is sampled.
- Arm latency: `ARM` sampled at edge k gives `ARMED`=1 after edge k.
- Trigger to siren:
  - `A` sampled at edge k gives `PENDING`=1 for exactly `ENTRY_DELAY` cycles (edges k+1 .. k+`ENTRY_DELAY`).
  - `SIREN`=1 from edge k+`ENTRY_DELAY` for exactly `SIREN_TIME` cycles.
  - `MEMO`=1 after that.
- Disarm latency: one edge. A `DISARM` sampled on the final ENTRY cycle wins; `SIREN` never asserts.
- `PENDING`, `SIREN` and `MEMO` are mutually exclusive. `ARMED` is high whenever any of them is high.
- `A` held high continuously while in MEMORY re-triggers immediately: one edge from MEMORY to ENTRY.

## Test plan
1. Reset, then `ARM` pulse, then `A`=1 for one cycle, with `ENTRY_DELAY`=4 and `SIREN_TIME`=6 -> `PENDING` high 4 cycles, `SIREN` high 6 cycles, then `MEMO`=1, `EVENTS`=1.
2. Armed, trigger, `DISARM` on the 4th ENTRY cycle -> DISARMED on the next edge, `SIREN` never high, `EVENTS`=1 retained.
3. `A`=1 while DISARMED for 20 cycles, plus `ARM` and `DISARM` asserted together -> all outputs stay 0, `EVENTS`=0.
4. Armed, `A` held high permanently -> repeated ENTRY/SIREN/MEMORY cycles. `EVENTS` counts 1..15, then stays 15 on the 16th and 17th triggers.
5. `rst_n` pulled low mid-SIREN (3rd cycle), asynchronous to `clk` -> `SIREN`, `ARMED` and `EVENTS` go to 0 before the next edge; after release the block stays DISARMED while `A`=1.
6. In MEMORY: `ARM` pulse has no effect (`EVENTS` unchanged); `A`=1 -> `PENDING`=1 after one edge and `EVENTS` increments by 1.

Source files
------------

// File: rtl/controle_sirene_alarme.sv
// Alarm siren controller: arming, entry delay, time-limited siren, alarm memory
// and a saturating trigger counter. Outputs are decoded from registered state only.
module controle_sirene_alarme #(
   parameter int unsigned ENTRY_DELAY = 10,
   parameter int unsigned SIREN_TIME  = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       A,
   input  logic       ARM,
   input  logic       DISARM,
   output logic       ARMED,
   output logic       PENDING,
   output logic       SIREN,
   output logic       MEMO,
   output logic [3:0] EVENTS
);

   typedef enum logic [2:0] {
      StDisarmed,
      StArmedIdle,
      StEntry,
      StSiren,
      StMemory
   } state_e;

   localparam logic [7:0] EntryLoad = 8'(ENTRY_DELAY - 1);
   localparam logic [7:0] SirenLoad = 8'(SIREN_TIME - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] events_q, events_d;
   logic [3:0] events_inc;

   assign events_inc = (events_q == 4'd15) ? events_q : events_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StDisarmed;
         cnt_q    <= 8'd0;
         events_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         events_q <= events_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      events_d = events_q;
      unique case (state_q)
         StDisarmed: begin
            // DISARM outranks ARM, so a coincident pair leaves us disarmed.
            if (ARM && !DISARM) begin
               state_d  = StArmedIdle;
               events_d = 4'd0;
            end
         end
         StArmedIdle, StMemory: begin
            if (DISARM) begin
               state_d = StDisarmed;
               cnt_d   = 8'd0;
            end else if (A) begin
               state_d  = StEntry;
               cnt_d    = EntryLoad;
               events_d = events_inc;
            end
         end
         StEntry: begin
            if (DISARM) begin
               state_d = StDisarmed;
               cnt_d   = 8'd0;
            end else if (cnt_q == 8'd0) begin
               state_d = StSiren;
               cnt_d   = SirenLoad;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StSiren: begin
            if (DISARM) begin
               state_d = StDisarmed;
               cnt_d   = 8'd0;
            end else if (cnt_q == 8'd0) begin
               state_d = StMemory;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = StDisarmed;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign ARMED   = (state_q != StDisarmed);
   assign PENDING = (state_q == StEntry);
   assign SIREN   = (state_q == StSiren);
   assign MEMO    = (state_q == StMemory);
   assign EVENTS  = events_q;

endmodule

// File: tb/tb_controle_sirene_alarme.sv
// Directed bench for controle_sirene_alarme with ENTRY_DELAY=4, SIREN_TIME=6.
// Observed vector is {ARMED, PENDING, SIREN, MEMO, EVENTS[3:0]}.
module tb_controle_sirene_alarme;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a = 1'b0;
   logic       arm = 1'b0;
   logic       disarm = 1'b0;
   logic       armed, pending, siren, memo;
   logic [3:0] events;
   logic [7:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   controle_sirene_alarme #(
      .ENTRY_DELAY(4),
      .SIREN_TIME (6)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (a),
      .ARM    (arm),
      .DISARM (disarm),
      .ARMED  (armed),
      .PENDING(pending),
      .SIREN  (siren),
      .MEMO   (memo),
      .EVENTS (events)
   );

   always #5 clk = ~clk;

   assign obs = {armed, pending, siren, memo, events};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      a      = 1'b0;
      arm    = 1'b0;
      disarm = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic arm_and_trigger();
      arm = 1'b1;
      step();
      arm = 1'b0;
      a   = 1'b1;
      step();
      a = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 8'b0000_0000) begin
         n_fail++;
         $display("FAIL reset_state: got %b expected %b", obs, 8'b0000_0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      n_checks++;
      if (obs !== 8'b0000_0000) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %b expected %b", obs, 8'b0000_0000);
      end
   endtask

   task automatic test_full_sequence();
      do_reset();
      arm = 1'b1;
      step();
      arm = 1'b0;
      n_checks++;
      if (obs !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL arm_latency: got %b expected %b", obs, 8'b1000_0000);
      end
      a = 1'b1;
      step();
      a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (obs !== 8'b1100_0001) begin
            n_fail++;
            $display("FAIL entry_cycle_%0d: got %b expected %b", i, obs, 8'b1100_0001);
         end
         step();
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (obs !== 8'b1010_0001) begin
            n_fail++;
            $display("FAIL siren_cycle_%0d: got %b expected %b", i, obs, 8'b1010_0001);
         end
         step();
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (obs !== 8'b1001_0001) begin
            n_fail++;
            $display("FAIL memory_cycle_%0d: got %b expected %b", i, obs, 8'b1001_0001);
         end
         step();
      end
   endtask

   task automatic test_disarm_last_entry();
      do_reset();
      arm_and_trigger();
      repeat (3) step();
      n_checks++;
      if (obs !== 8'b1100_0001) begin
         n_fail++;
         $display("FAIL disarm_pre_entry: got %b expected %b", obs, 8'b1100_0001);
      end
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (obs !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL disarm_hold_%0d: got %b expected %b", i, obs, 8'b0000_0001);
         end
         step();
      end
   endtask

   task automatic test_disarmed_ignores();
      do_reset();
      a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         arm    = (i == 5 || i == 12);
         disarm = (i == 5 || i == 12);
         step();
         n_checks++;
         if (obs !== 8'b0000_0000) begin
            n_fail++;
            $display("FAIL disarmed_ignore_%0d: got %b expected %b", i, obs, 8'b0000_0000);
         end
      end
      a      = 1'b0;
      arm    = 1'b0;
      disarm = 1'b0;
   endtask

   task automatic test_saturation();
      logic [7:0] exp;
      do_reset();
      arm = 1'b1;
      step();
      arm = 1'b0;
      a   = 1'b1;
      step();
      n_checks++;
      if (obs !== 8'b1100_0001) begin
         n_fail++;
         $display("FAIL sat_trigger_1: got %b expected %b", obs, 8'b1100_0001);
      end
      for (int t = 2; t <= 17; t++) begin
         repeat (10) step();
         exp = {4'b1001, 4'((t - 1 > 15) ? 15 : t - 1)};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL sat_memo_%0d: got %b expected %b", t, obs, exp);
         end
         step();
         exp = {4'b1100, 4'((t > 15) ? 15 : t)};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL sat_trigger_%0d: got %b expected %b", t, obs, exp);
         end
      end
      a = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      arm_and_trigger();
      repeat (6) step();
      n_checks++;
      if (obs !== 8'b1010_0001) begin
         n_fail++;
         $display("FAIL async_pre_siren: got %b expected %b", obs, 8'b1010_0001);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 8'b0000_0000) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got %b expected %b", obs, 8'b0000_0000);
      end
      #2;
      rst_n = 1'b1;
      a     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (obs !== 8'b0000_0000) begin
            n_fail++;
            $display("FAIL async_post_release_%0d: got %b expected %b", i, obs, 8'b0000_0000);
         end
      end
      a = 1'b0;
   endtask

   task automatic test_memory_rearm_retrigger();
      do_reset();
      arm_and_trigger();
      repeat (10) step();
      n_checks++;
      if (obs !== 8'b1001_0001) begin
         n_fail++;
         $display("FAIL mem_reached: got %b expected %b", obs, 8'b1001_0001);
      end
      arm = 1'b1;
      step();
      arm = 1'b0;
      n_checks++;
      if (obs !== 8'b1001_0001) begin
         n_fail++;
         $display("FAIL mem_arm_ignored: got %b expected %b", obs, 8'b1001_0001);
      end
      a = 1'b1;
      step();
      a = 1'b0;
      n_checks++;
      if (obs !== 8'b1100_0010) begin
         n_fail++;
         $display("FAIL mem_retrigger: got %b expected %b", obs, 8'b1100_0010);
      end
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_disarm_last_entry();
      test_disarmed_ignores();
      test_saturation();
      test_async_reset();
      test_memory_rearm_retrigger();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
